// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the controller (slave).
// The datapath reports stage operands and memory status; the controller returns enables/flushes.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic             mem_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_memread, ex_rd,
           mem_branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, mem_timeout, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_memread, ex_rd,
           mem_branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LEGv8 pipeline: load-use bubbles, MEM-resolved
// branch flushes and multi-cycle data-memory waits, with a stall counter and timeout flag.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned XZR      = 31,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned WAIT_W   = 5,
  parameter int unsigned CNT_W    = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  localparam logic [WAIT_W-1:0] WaitMax = WAIT_W'(MAX_WAIT);
  localparam logic [REG_W-1:0]  ZeroReg = REG_W'(XZR);
  localparam logic [CNT_W-1:0]  CntMax  = '1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic memstall, loaduse, resolve;
  logic [4:0] en;   // {pc, ifid, idex, exmem, memwb}
  logic [2:0] fl;   // {ifid, idex, exmem}

  assign memstall = hz.mem_req & ~hz.mem_ready;
  assign loaduse  = hz.ex_memread && (hz.ex_rd != ZeroReg) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // Normal hazard rules apply in RUN without a memory stall, or on the MEM_WAIT release cycle.
  assign resolve = ~reset & (((state_q == StRun) & ~memstall) |
                             ((state_q == StMemWait) & hz.mem_ready));

  always_comb begin
    en = 5'b00000;
    fl = 3'b000;
    if (resolve) begin
      if (hz.mem_branch_taken) begin
        en = 5'b11111;
        fl = 3'b111;
      end else if (loaduse) begin
        en = 5'b00111;
        fl = 3'b010;
      end else begin
        en = 5'b11111;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      StRun: begin
        if (memstall) state_d = StMemWait;
      end
      StMemWait: begin
        if (hz.mem_ready) begin
          state_d = StRun;
          wait_d  = '0;
        end else begin
          if (wait_q != WaitMax) wait_d = wait_q + 1'b1;
          if (wait_d == WaitMax) timeout_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
    if (!en[4] && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_en       = en[4];
  assign hz.ifid_en     = en[3];
  assign hz.idex_en     = en[2];
  assign hz.exmem_en    = en[1];
  assign hz.memwb_en    = en[0];
  assign hz.ifid_flush  = fl[2];
  assign hz.idex_flush  = fl[1];
  assign hz.exmem_flush = fl[0];
  assign hz.mem_timeout = timeout_q;
  assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and stall controller for the 5-stage LEGv8 pipeline. It sequences the enable-gated pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and their flushes. It handles three cases: load-use bubbles, branch flushes resolved in MEM, and multi-cycle data-memory waits. It also keeps a saturating stall counter and a sticky memory-timeout flag.

Parameters:
REG_W, 5, register specifier width
XZR, 31, zero-register index; it never creates a hazard
MAX_WAIT, 16, MEM_WAIT cycles before mem_timeout sets (range 1..2^WAIT_W-1)
WAIT_W, 5, wait counter width
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
id_rs1  in  REG_W  ID-stage source reg 1
id_rs2  in  REG_W  ID-stage source reg 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_memread  in  1  EX instruction is a load
ex_rd  in  REG_W  EX destination reg
mem_branch_taken  in  1  MEM-stage branch resolved taken
mem_req  in  1  MEM-stage data-memory access valid
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC register enable
ifid_en  out  1  IF/ID enable
idex_en  out  1  ID/EX enable
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
ifid_flush  out  1  IF/ID loads bubble
idex_flush  out  1  ID/EX loads bubble
exmem_flush  out  1  EX/MEM loads bubble
mem_timeout  out  1  sticky: wait exceeded MAX_WAIT
stall_cnt  out  CNT_W  cycles with pc_en=0, saturating

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset).
- Reset state: state=RUN, wait counter 0, stall_cnt 0, mem_timeout 0. While reset is high, all *_en=0 and all *_flush=0.
- States: RUN, MEM_WAIT. The enables and flushes are combinational from the state and the current inputs. Flush takes effect only when the matching register's enable is also 1.
- Definitions:
  - memstall = mem_req & ~mem_ready.
  - loaduse = ex_memread & ex_rd!=XZR & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN, priority highest first:
  1. memstall: all 5 enables=0, no flush; next state MEM_WAIT.
  2. mem_branch_taken: all enables=1; ifid_flush=idex_flush=exmem_flush=1; PC loads the target. Any loaduse is ignored because the instruction is squashed.
  3. loaduse: pc_en=ifid_en=0; idex_en=1 with idex_flush=1; exmem_en=memwb_en=1. This is a 1-cycle bubble.
  4. Otherwise all enables=1, flushes=0.
- MEM_WAIT:
  - mem_ready=0: all enables=0, flushes=0, stay in MEM_WAIT. Wait counter increments. When it reaches MAX_WAIT, mem_timeout sets.
  - mem_ready=1: apply RUN rules 2-4 to the current inputs; memstall is ignored. Next state RUN, wait counter cleared.
  - mem_timeout does not unfreeze the pipeline. It stays set until reset.
- Wait counter saturates at MAX_WAIT; no wrap.
- mem_branch_taken during a memory stall is not acted on. The frozen EX/MEM register holds it until the stall releases.
- stall_cnt increments on every cycle with pc_en=0, reset deasserted. It saturates at 2^CNT_W-1.
- Reset asserted mid-MEM_WAIT: immediate return to RUN; all counters and flags clear.

Test Plan:
- Load-use: ex_memread=1, ex_rd=3, id_rs1=3, id_uses_rs1=1, RUN -> that cycle pc_en=ifid_en=0, idex_flush=1, idex_en=1; next cycle (ex_memread=0) all en=1; stall_cnt=1.
- XZR: the same case with ex_rd=id_rs1=31 -> no stall; all en=1, stall_cnt=0.
- Branch plus load-use together: mem_branch_taken=1 with loaduse true -> all en=1; ifid/idex/exmem_flush=1; stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all en=0 for 3 cycles, en=1 on the ready cycle, state RUN; stall_cnt=3, mem_timeout=0.
- Timeout: MAX_WAIT=4, mem_req=1, mem_ready=0 for 10 cycles -> mem_timeout=1 from the cycle after 4 wait cycles; enables remain 0. Then mem_ready=1 -> pipeline resumes, mem_timeout still 1 until reset.
- Reset mid-wait, plus saturation: assert reset in MEM_WAIT -> enables 0 and stall_cnt=0 immediately, RUN after release. With CNT_W=4, 20 stall cycles -> stall_cnt holds 15.
